// File: rtl/fifo_package.sv
// +----------------------------------------------------------------------------
// | fifo_package: shared parity-FIFO constants and arbiter state encoding.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package fifo_package;
  localparam int    WIDTH             = 32;
  localparam int    DATA_WIDTH        = WIDTH + 1;
  localparam string PARITY_BIT        = "MSB";
  localparam string PARITY_TYPE       = "EVEN";
  localparam int    N_REQ_DEFAULT     = 4;
  localparam int    MAX_BURST_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
// +----------------------------------------------------------------------------
// | fifo_wr_arbiter_if: producer request bus plus FIFO write port.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface fifo_wr_arbiter_if
  import fifo_package::*;
#(
  parameter int N_REQ      = N_REQ_DEFAULT,
  parameter int WIDTH      = fifo_package::WIDTH,
  parameter int DATA_WIDTH = fifo_package::DATA_WIDTH
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_full;
  logic                   fifo_wr_en;
  logic [DATA_WIDTH-1:0]  fifo_wr_data;
  logic [GW-1:0]          grant_id;
  logic                   busy;

  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/parity_encoder.sv
// +----------------------------------------------------------------------------
// | parity_encoder: appends an even/odd parity bit at the MSB or LSB.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module parity_encoder
  import fifo_package::*;
#(
  parameter int    WIDTH       = fifo_package::WIDTH,
  parameter int    DATA_WIDTH  = fifo_package::DATA_WIDTH,
  parameter string PARITY_BIT  = fifo_package::PARITY_BIT,
  parameter string PARITY_TYPE = fifo_package::PARITY_TYPE
) (
  input  wire logic [WIDTH-1:0]      i_payload,
  output logic      [DATA_WIDTH-1:0] o_word
);
  logic w_parity;

  assign w_parity = (PARITY_TYPE == "ODD") ? ~^i_payload : ^i_payload;

  generate
    if (PARITY_BIT == "LSB") begin : g_lsb
      assign o_word = {i_payload, w_parity};
    end else begin : g_msb
      assign o_word = {w_parity, i_payload};
    end
  endgenerate
endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// +----------------------------------------------------------------------------
// | fifo_wr_arbiter: round-robin burst arbiter onto one parity FIFO write port.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter
  import fifo_package::*;
#(
  parameter int    N_REQ       = N_REQ_DEFAULT,
  parameter int    MAX_BURST   = MAX_BURST_DEFAULT,
  parameter int    WIDTH       = fifo_package::WIDTH,
  parameter int    DATA_WIDTH  = fifo_package::DATA_WIDTH,
  parameter string PARITY_BIT  = fifo_package::PARITY_BIT,
  parameter string PARITY_TYPE = fifo_package::PARITY_TYPE
) (
  input wire logic          clk,
  input wire logic          rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  logic [BW-1:0]   r_beat_cnt;

  logic [WIDTH-1:0]      w_payloads [N_REQ];
  logic [WIDTH-1:0]      w_payload;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_fire;
  logic                  w_burst_end;
  logic [GW-1:0]         w_next_ptr;
  logic                  w_found;
  logic [GW-1:0]         w_sel;
  logic [GW-1:0]         w_idx;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_payloads[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_payload   = w_payloads[r_grant_id];
  assign w_fire      = (r_state == XFER) && bus.req_valid[r_grant_id] && !bus.fifo_full;
  assign w_burst_end = w_fire && (bus.req_last[r_grant_id] ||
                                  (r_beat_cnt == BW'(MAX_BURST - 1)));
  assign w_next_ptr  = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  parity_encoder #(
    .WIDTH       (WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY_BIT  (PARITY_BIT),
    .PARITY_TYPE (PARITY_TYPE)
  ) u_parity_encoder (
    .i_payload (w_payload),
    .o_word    (w_word)
  );

  always_comb begin
    bus.req_ready = '0;
    if (r_state == XFER && !bus.fifo_full) begin
      bus.req_ready[r_grant_id] = 1'b1;
    end
  end

  assign bus.fifo_wr_en   = w_fire;
  assign bus.fifo_wr_data = w_fire ? w_word : '0;
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = (r_state == XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id <= w_sel;
            r_beat_cnt <= '0;
            r_state    <= XFER;
          end
        end
        XFER: begin
          if (w_fire) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_burst_end) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// +----------------------------------------------------------------------------
// | tb_fifo_wr_arbiter: scoreboard + vector-table bench for fifo_wr_arbiter.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arbiter;
  typedef struct {
    logic [31:0] d;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  gid;
    logic [32:0] word;
  } exp_t;

  typedef struct {
    int          req;
    logic [31:0] data;
    logic [32:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(4), .WIDTH(32), .DATA_WIDTH(33)) bus ();
  fifo_wr_arbiter_if #(.N_REQ(4), .WIDTH(32), .DATA_WIDTH(33)) bus2 ();

  fifo_wr_arbiter #(
    .N_REQ(4), .MAX_BURST(4), .WIDTH(32), .DATA_WIDTH(33),
    .PARITY_BIT("MSB"), .PARITY_TYPE("EVEN")
  ) u_dut (.clk(clk), .rst(rst), .bus(bus.master));

  fifo_wr_arbiter #(
    .N_REQ(4), .MAX_BURST(4), .WIDTH(32), .DATA_WIDTH(33),
    .PARITY_BIT("LSB"), .PARITY_TYPE("ODD")
  ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  int    n_checks    = 0;
  int    n_fail      = 0;
  int    cyc         = 0;
  int    wr_count    = 0;
  int    busy_cycles = 0;
  int    stamps[$];
  beat_t q[4][$];
  exp_t  sb[$];
  exp_t  e;
  logic [3:0] hold      = '0;
  logic [3:0] acc       = '0;
  logic       full_ctrl = 1'b0;
  vec_t       vecs[5];

  function automatic logic [32:0] pe(input logic [31:0] d);
    return {^d, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input int r, input logic [31:0] d, input logic last);
    beat_t b;
    b.d = d;
    b.last = last;
    q[r].push_back(b);
  endtask

  task automatic expect_wr(input int r, input logic [32:0] w);
    exp_t x;
    x.gid  = 2'(r);
    x.word = w;
    sb.push_back(x);
  endtask

  task automatic flush();
    sb.delete();
    for (int i = 0; i < 4; i++) q[i].delete();
    acc = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    full_ctrl = 1'b0;
    hold = '0;
    flush();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int c = 0;
    while (wr_count < n && c < 100) begin
      @(posedge clk);
      c++;
    end
    if (wr_count < n) check("wait_writes_timeout", 64'(wr_count), 64'(n));
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((sb.size() > 0 || q[0].size() > 0 || q[1].size() > 0 ||
            q[2].size() > 0 || q[3].size() > 0 || bus.busy) && c < 200) begin
      @(posedge clk);
      c++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic dut2_beat(input int r, input logic [31:0] d, input logic [32:0] w);
    bit seen = 0;
    @(negedge clk);
    bus2.req_data = '0;
    bus2.req_data[r*32 +: 32] = d;
    bus2.req_valid = 4'(1 << r);
    bus2.req_last  = 4'(1 << r);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); #1;
      if (bus2.fifo_wr_en) begin
        seen = 1;
        check("odd_lsb_word", 64'(bus2.fifo_wr_data), 64'(w));
      end
    end
    if (!seen) check("odd_lsb_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus2.req_valid = '0;
    bus2.req_last  = '0;
  endtask

  // Producer agents and monitor share one negedge process so inputs settle
  // before the monitor samples, and accepts are retired a cycle later.
  always @(negedge clk) begin
    logic [3:0]   v;
    logic [3:0]   l;
    logic [127:0] d;
    for (int i = 0; i < 4; i++) if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
    v = '0; l = '0; d = '0;
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0 && !hold[i]) begin
        v[i] = 1'b1;
        l[i] = q[i][0].last;
        d[i*32 +: 32] = q[i][0].d;
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.fifo_full = full_ctrl;
    #1;
    acc = bus.req_valid & bus.req_ready;
    cyc++;
    if (bus.busy) busy_cycles++;
    if (!bus.busy) check("idle_quiet", 64'({bus.req_ready, bus.fifo_wr_en}), 64'd0);
    if (bus.fifo_full) check("full_quiet", 64'({bus.req_ready, bus.fifo_wr_en}), 64'd0);
    if (bus.fifo_wr_en) begin
      wr_count++;
      stamps.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %h, expected no write", bus.fifo_wr_data);
      end else begin
        e = sb.pop_front();
        check("wr_grant", 64'(bus.grant_id), 64'(e.gid));
        check("wr_data", 64'(bus.fifo_wr_data), 64'(e.word));
      end
    end else begin
      check("wr_data_zero", 64'(bus.fifo_wr_data), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int base;
    vecs[0] = '{0, 32'h0000_0000, 33'h0_0000_0000};
    vecs[1] = '{1, 32'hFFFF_FFFF, 33'h0_FFFF_FFFF};
    vecs[2] = '{2, 32'h8000_0000, 33'h1_8000_0000};
    vecs[3] = '{3, 32'h1234_5678, 33'h1_1234_5678};
    vecs[4] = '{1, 32'h0000_0007, 33'h1_0000_0007};

    rst = 1'b1;
    bus2.req_valid = '0;
    bus2.req_last  = '0;
    bus2.req_data  = '0;
    bus2.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_grant", 64'(bus.grant_id), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("rst_wr_data", 64'(bus.fifo_wr_data), 64'd0);
    rst = 1'b0;

    // Single-beat parity vectors, EVEN/MSB
    for (int k = 0; k < 5; k++) begin
      send(vecs[k].req, vecs[k].data, 1'b1);
      expect_wr(vecs[k].req, vecs[k].exp);
      wait_drain("vec");
    end

    // Two-beat burst: one bubble, then back-to-back writes
    do_reset();
    stamps.delete();
    busy_cycles = 0;
    s = cyc;
    send(0, 32'h0000_0001, 1'b0);
    send(0, 32'h0000_0003, 1'b1);
    expect_wr(0, 33'h1_0000_0001);
    expect_wr(0, 33'h0_0000_0003);
    wait_drain("t1");
    check("t1_writes", 64'(stamps.size()), 64'd2);
    if (stamps.size() >= 2) begin
      check("t1_latency", 64'(stamps[0] - s), 64'd2);
      check("t1_back2back", 64'(stamps[1] - stamps[0]), 64'd1);
    end
    check("t1_busy_cycles", 64'(busy_cycles), 64'd2);

    // Round-robin fairness with single-beat bursts
    do_reset();
    stamps.delete();
    for (int i = 0; i < 4; i++) send(i, 32'hA0 + 32'(i), 1'b1);
    send(0, 32'hB0, 1'b1);
    for (int i = 0; i < 4; i++) expect_wr(i, pe(32'hA0 + 32'(i)));
    expect_wr(0, pe(32'hB0));
    wait_drain("t2");
    check("t2_writes", 64'(stamps.size()), 64'd5);
    if (stamps.size() >= 5)
      for (int k = 0; k < 4; k++) check("t2_gap", 64'(stamps[k+1] - stamps[k]), 64'd2);

    // MAX_BURST cut-off hands over to the next valid requester
    do_reset();
    for (int k = 0; k < 6; k++) send(2, 32'h200 + 32'(k), k == 5);
    send(3, 32'h300, 1'b1);
    for (int k = 0; k < 4; k++) expect_wr(2, pe(32'h200 + 32'(k)));
    expect_wr(3, pe(32'h300));
    for (int k = 4; k < 6; k++) expect_wr(2, pe(32'h200 + 32'(k)));
    wait_drain("t3");

    // FIFO full stall must not advance the beat count
    do_reset();
    for (int k = 0; k < 5; k++) send(0, 32'h400 + 32'(k), k == 4);
    send(1, 32'h410, 1'b1);
    for (int k = 0; k < 4; k++) expect_wr(0, pe(32'h400 + 32'(k)));
    expect_wr(1, pe(32'h410));
    expect_wr(0, pe(32'h404));
    base = wr_count;
    wait_writes(base + 1);
    #1 full_ctrl = 1'b1;
    repeat (3) @(posedge clk);
    #1 full_ctrl = 1'b0;
    wait_drain("t4");

    // Granted requester drops valid; grant is held
    do_reset();
    for (int k = 0; k < 3; k++) send(1, 32'h510 + 32'(k), k == 2);
    for (int k = 0; k < 3; k++) expect_wr(1, pe(32'h510 + 32'(k)));
    expect_wr(0, pe(32'h500));
    base = wr_count;
    wait_writes(base + 1);
    #1 hold[1] = 1'b1;
    send(0, 32'h500, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #2;
      check("t5_hold_grant", 64'(bus.grant_id), 64'd1);
      check("t5_hold_busy", 64'(bus.busy), 64'd1);
      check("t5_hold_ready", 64'({bus.req_ready, bus.fifo_wr_en}), 64'b0010_0);
    end
    @(posedge clk); #1 hold[1] = 1'b0;
    wait_drain("t5");

    // Reset mid-burst: outputs clear immediately and rr pointer restarts
    do_reset();
    send(2, 32'h600, 1'b1);
    expect_wr(2, pe(32'h600));
    wait_drain("t6a");
    for (int k = 0; k < 3; k++) send(1, 32'h610 + 32'(k), k == 2);
    for (int k = 0; k < 3; k++) expect_wr(1, pe(32'h610 + 32'(k)));
    base = wr_count;
    wait_writes(base + 1);
    @(negedge clk); #3;
    check("t6_beat2_present", 64'(bus.fifo_wr_en), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("t6_rst_wr_data", 64'(bus.fifo_wr_data), 64'd0);
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    check("t6_rst_ready", 64'(bus.req_ready), 64'd0);
    check("t6_rst_grant", 64'(bus.grant_id), 64'd0);
    flush();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(3, 32'h630, 1'b1);
    send(0, 32'h600, 1'b1);
    expect_wr(0, pe(32'h600));
    expect_wr(3, pe(32'h630));
    wait_drain("t6b");

    // ODD/LSB variant
    dut2_beat(0, 32'h0000_0001, 33'h0_0000_0002);
    dut2_beat(1, 32'h0000_0003, 33'h0_0000_0007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
